// File: rtl/fixed_point_pkg.sv
// Shared Q1.15 fixed-point types and constants for the state-vector datapath,
// plus the H-gate sequencer state encoding.
package fixed_point_pkg;

    typedef logic signed [15:0] q15_t;

    localparam q15_t INV_SQRT2 = 16'sh5A82;

    typedef struct packed {
        q15_t r;
        q15_t i;
    } cplx_q15_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_A,
        ST_RD_B,
        ST_CAP,
        ST_WR_A,
        ST_WR_B,
        ST_DONE
    } hseq_state_e;

endpackage

// File: rtl/gate_h.sv
// Combinational Hadamard butterfly: out0 = (a+b)/sqrt2, out1 = (a-b)/sqrt2 per component.
// Zero latency, no flow control; results wrap to 16 bits and round toward -inf.
module gate_h
    import fixed_point_pkg::*;
(
    input  cplx_q15_t a,
    input  cplx_q15_t b,
    output cplx_q15_t out0,
    output cplx_q15_t out1
);

    function automatic q15_t scale(input logic signed [16:0] s);
        logic signed [31:0] se;
        logic signed [31:0] ce;
        logic signed [31:0] p;
        se = {{15{s[16]}}, s};
        ce = {{16{INV_SQRT2[15]}}, INV_SQRT2};
        p  = se * ce;
        // Bits [30:15] are the arithmetic >>>15 truncated back to 16 bits.
        return p[30:15];
    endfunction

    logic signed [16:0] sum_r, sum_i, dif_r, dif_i;

    always_comb begin
        sum_r = {a.r[15], a.r} + {b.r[15], b.r};
        sum_i = {a.i[15], a.i} + {b.i[15], b.i};
        dif_r = {a.r[15], a.r} - {b.r[15], b.r};
        dif_i = {a.i[15], a.i} - {b.i[15], b.i};
        out0.r = scale(sum_r);
        out0.i = scale(sum_i);
        out1.r = scale(dif_r);
        out1.i = scale(dif_i);
    end

endmodule

// File: rtl/h_gate_sequencer.sv
// In-place Hadamard over the whole amplitude RAM, one pair per 5 cycles (read a, read b, capture, write a, write b).
// Latency 5*2^(N_QUBITS-1) cycles from start to done; start is ignored while busy.
module h_gate_sequencer
    import fixed_point_pkg::*;
#(
    parameter int N_QUBITS = 4,
    parameter int ADDR_W   = N_QUBITS,
    parameter int TGT_W    = (N_QUBITS > 1) ? $clog2(N_QUBITS) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [TGT_W-1:0]    target,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic                mem_we,
    output logic signed [15:0]  mem_wr_r,
    output logic signed [15:0]  mem_wr_i,
    input  logic signed [15:0]  mem_rd_r,
    input  logic signed [15:0]  mem_rd_i
);

    localparam logic [ADDR_W-2:0] K_LAST = '1;
    localparam logic [TGT_W:0]    N_TGT  = (TGT_W+1)'(N_QUBITS);

    hseq_state_e         state;
    logic [TGT_W-1:0]    tgt_q;
    logic [ADDR_W-2:0]   k;
    logic                err_q;
    cplx_q15_t           amp_a, amp_b;
    cplx_q15_t           bf0, bf1, wr_dat;
    logic [ADDR_W-2:0]   k_nxt;
    logic [ADDR_W-1:0]   addr_a, addr_b, addr_a_nxt;
    logic                target_ok;

    // Pair index k with a zero spliced in at bit t gives the lower address of the pair.
    function automatic logic [ADDR_W-1:0] ins_zero(input logic [ADDR_W-2:0] kk,
                                                   input logic [TGT_W-1:0]  t);
        logic [ADDR_W-1:0] kx;
        logic [ADDR_W-1:0] low_mask;
        kx       = {1'b0, kk};
        low_mask = (ADDR_W'(1) << t) - ADDR_W'(1);
        return (kx & low_mask) | ((kx & ~low_mask) << 1);
    endfunction

    always_comb begin
        k_nxt      = k + 1'b1;
        addr_a     = ins_zero(k, tgt_q);
        addr_b     = addr_a | (ADDR_W'(1) << tgt_q);
        addr_a_nxt = ins_zero(k_nxt, tgt_q);
        target_ok  = {1'b0, target} < N_TGT;
    end

    gate_h u_bfly (
        .a    (amp_a),
        .b    (amp_b),
        .out0 (bf0),
        .out1 (bf1)
    );

    // Write data is decoded from state so it is zero whenever reset forces IDLE.
    always_comb begin
        wr_dat = '0;
        if (state == ST_WR_A)      wr_dat = bf0;
        else if (state == ST_WR_B) wr_dat = bf1;
    end

    assign mem_wr_r = wr_dat.r;
    assign mem_wr_i = wr_dat.i;

    // Outputs are loaded on the edge entering each state so they are valid for that whole state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            tgt_q    <= '0;
            k        <= '0;
            err_q    <= 1'b0;
            amp_a    <= '0;
            amp_b    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            mem_we   <= 1'b0;
            mem_addr <= '0;
        end else begin
            done   <= 1'b0;
            err    <= 1'b0;
            mem_we <= 1'b0;
            case (state)
                ST_IDLE: begin
                    mem_addr <= '0;
                    if (start) begin
                        tgt_q <= target;
                        k     <= '0;
                        busy  <= 1'b1;
                        if (target_ok) begin
                            err_q <= 1'b0;
                            state <= ST_RD_A;
                        end else begin
                            err_q <= 1'b1;
                            state <= ST_DONE;
                            done  <= 1'b1;
                            err   <= 1'b1;
                        end
                    end
                end
                ST_RD_A: begin
                    state    <= ST_RD_B;
                    mem_addr <= addr_b;
                end
                ST_RD_B: begin
                    amp_a    <= '{r: mem_rd_r, i: mem_rd_i};
                    state    <= ST_CAP;
                    mem_addr <= addr_a;
                end
                ST_CAP: begin
                    amp_b    <= '{r: mem_rd_r, i: mem_rd_i};
                    state    <= ST_WR_A;
                    mem_addr <= addr_a;
                    mem_we   <= 1'b1;
                end
                ST_WR_A: begin
                    state    <= ST_WR_B;
                    mem_addr <= addr_b;
                    mem_we   <= 1'b1;
                end
                ST_WR_B: begin
                    if (k == K_LAST) begin
                        state    <= ST_DONE;
                        done     <= 1'b1;
                        err      <= err_q;
                        mem_addr <= '0;
                    end else begin
                        k        <= k_nxt;
                        state    <= ST_RD_A;
                        mem_addr <= addr_a_nxt;
                    end
                end
                ST_DONE: begin
                    state    <= ST_IDLE;
                    busy     <= 1'b0;
                    mem_addr <= '0;
                end
                default: begin
                    state    <= ST_IDLE;
                    busy     <= 1'b0;
                    mem_addr <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_h_gate_sequencer.sv
// Bench for h_gate_sequencer: behavioural RAM plus a pair-wise Hadamard reference model.
module tb_h_gate_sequencer;

    logic               clk;
    logic               rst_n;
    logic               start;
    logic [2:0]         target;
    logic               busy, done, err, mem_we;
    logic [3:0]         mem_addr;
    logic signed [15:0] mem_wr_r, mem_wr_i, mem_rd_r, mem_rd_i;
    logic [39:0]        outs;

    logic signed [15:0] ram_r [16];
    logic signed [15:0] ram_i [16];
    logic               ld_we;
    logic [3:0]         ld_addr;
    logic signed [15:0] ld_r, ld_i;

    logic signed [15:0] mr [16];
    logic signed [15:0] mi [16];

    int checks = 0;
    int errors = 0;
    int lat, we_cnt, done_cnt;
    logic err_seen;
    logic [3:0] addr_q[$];
    logic       we_q[$];

    h_gate_sequencer #(.N_QUBITS(4), .TGT_W(3)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .target   (target),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .mem_addr (mem_addr),
        .mem_we   (mem_we),
        .mem_wr_r (mem_wr_r),
        .mem_wr_i (mem_wr_i),
        .mem_rd_r (mem_rd_r),
        .mem_rd_i (mem_rd_i)
    );

    assign outs = {busy, done, err, mem_we, mem_addr, mem_wr_r, mem_wr_i};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ld_we) begin
            ram_r[ld_addr] <= ld_r;
            ram_i[ld_addr] <= ld_i;
        end else if (mem_we) begin
            ram_r[mem_addr] <= mem_wr_r;
            ram_i[mem_addr] <= mem_wr_i;
        end
        mem_rd_r <= ram_r[mem_addr];
        mem_rd_i <= ram_i[mem_addr];
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One component of the butterfly: floor((x +/- y) * 0x5A82 / 2^15), wrapped to 16 bits.
    function automatic logic signed [15:0] h_lane(input int x, input int y, input bit diff);
        int s, p;
        s = diff ? x - y : x + y;
        p = s * 23170;
        return 16'(p >>> 15);
    endfunction

    // Apply H on qubit t to the first max_pairs pairs, in ascending lower-index order.
    task automatic model_h(input int t, input int max_pairs);
        int n;
        n = 0;
        for (int i = 0; i < 16; i++) begin
            if (((i >> t) & 1) == 0 && n < max_pairs) begin
                int j;
                logic signed [15:0] ar, ai, br, bi;
                j  = i | (1 << t);
                ar = mr[i]; ai = mi[i]; br = mr[j]; bi = mi[j];
                mr[i] = h_lane(ar, br, 1'b0);
                mi[i] = h_lane(ai, bi, 1'b0);
                mr[j] = h_lane(ar, br, 1'b1);
                mi[j] = h_lane(ai, bi, 1'b1);
                n++;
            end
        end
    endtask

    task automatic load_ram();
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            ld_we = 1'b1; ld_addr = 4'(i); ld_r = mr[i]; ld_i = mi[i];
        end
        @(negedge clk);
        ld_we = 1'b0;
    endtask

    task automatic check_ram(input string tag);
        for (int i = 0; i < 16; i++)
            check($sformatf("%s_amp%0d", tag, i), {ram_r[i], ram_i[i]}, {mr[i], mi[i]});
    endtask

    // Issue start, then record the bus every cycle until done (bounded); poke_at>=0 re-pulses start mid-run.
    task automatic run(input int t, input int poke_at);
        addr_q.delete(); we_q.delete(); we_cnt = 0;
        @(negedge clk);
        start = 1'b1; target = 3'(t);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; lat = 0;
        while (!done && lat < 200) begin
            addr_q.push_back(mem_addr);
            we_q.push_back(mem_we);
            if (mem_we) we_cnt++;
            if (lat == poke_at) begin start = 1'b1; target = 3'd5; end
            else start = 1'b0;
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        err_seen = err;
    endtask

    task automatic check_seq(input int t);
        int pair_a[$];
        for (int i = 0; i < 16; i++)
            if (((i >> t) & 1) == 0) pair_a.push_back(i);
        check("seq_len", 64'(addr_q.size()), 64'd40);
        if (addr_q.size() == 40) begin
            for (int k = 0; k < 8; k++) begin
                for (int s = 0; s < 5; s++) begin
                    int idx, ea;
                    idx = 5 * k + s;
                    ea  = (s == 1 || s == 4) ? (pair_a[k] | (1 << t)) : pair_a[k];
                    if (s == 2) check($sformatf("we_p%0d_s%0d", k, s), {63'd0, we_q[idx]}, 64'd0);
                    else check($sformatf("bus_p%0d_s%0d", k, s), {59'd0, we_q[idx], addr_q[idx]},
                               {59'd0, (s >= 3), 4'(ea)});
                end
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; target = '0;
        ld_we = 1'b0; ld_addr = '0; ld_r = '0; ld_i = '0;
        repeat (2) @(negedge clk);
        check("reset_outs", {24'd0, outs}, 64'd0);
        rst_n = 1'b1;

        // H on |0>, target 0
        for (int i = 0; i < 16; i++) begin mr[i] = '0; mi[i] = '0; end
        mr[0] = 16'sh7FFF;
        load_ram();
        run(0, -1);
        model_h(0, 8);
        check("h0_latency", 64'(lat), 64'd40);
        check("h0_err", {63'd0, err_seen}, 64'd0);
        check("h0_amp0", {48'd0, ram_r[0]}, 64'h5A81);
        check("h0_amp1", {48'd0, ram_r[1]}, 64'h5A81);
        check_ram("h0");
        check_seq(0);

        // Second H restores |0> with floor truncation
        run(0, -1);
        model_h(0, 8);
        check("hh_amp0", {ram_r[0], ram_i[0]}, 64'h7FFD_0000);
        check("hh_amp1", {ram_r[1], ram_i[1]}, 64'd0);
        check_ram("hh");

        // Random amplitudes and targets; first run also pokes start while busy
        for (int r = 0; r < 3; r++) begin
            int t;
            t = $urandom_range(0, 3);
            for (int i = 0; i < 16; i++) begin
                mr[i] = 16'($urandom); mi[i] = 16'($urandom);
            end
            load_ram();
            run(t, (r == 0) ? 10 : -1);
            model_h(t, 8);
            check($sformatf("rnd%0d_latency", r), 64'(lat), 64'd40);
            check($sformatf("rnd%0d_err", r), {63'd0, err_seen}, 64'd0);
            check_seq(t);
            check_ram($sformatf("rnd%0d", r));
            if (r == 0) begin
                done_cnt = 0;
                for (int c = 0; c < 60; c++) begin
                    @(negedge clk);
                    if (done) done_cnt++;
                end
                check("busy_start_ignored", 64'(done_cnt), 64'd0);
                check("busy_start_idle", {63'd0, busy}, 64'd0);
            end
        end

        // Out-of-range target
        run(5, -1);
        check("inv_latency", 64'(lat), 64'd0);
        check("inv_done_err", {62'd0, done, err_seen}, 64'd3);
        check("inv_no_we", 64'(we_cnt), 64'd0);
        @(negedge clk);
        check("inv_done_pulse", {62'd0, done, err}, 64'd0);
        @(negedge clk);
        check("inv_idle", {63'd0, busy}, 64'd0);

        // Reset during WR_A of pair 3
        for (int i = 0; i < 16; i++) begin
            mr[i] = 16'($urandom_range(0, 16383)); mi[i] = 16'($urandom_range(0, 16383));
        end
        load_ram();
        @(negedge clk);
        start = 1'b1; target = 3'd0;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; lat = 0;
        while (lat < 18) begin @(negedge clk); lat++; end
        check("pre_rst_wr_a", {59'd0, mem_we, mem_addr}, {59'd0, 1'b1, 4'd6});
        rst_n = 1'b0;
        #1;
        check("mid_rst_outs", {24'd0, outs}, 64'd0);
        @(negedge clk);
        model_h(0, 3);
        check_ram("partial");
        rst_n = 1'b1;
        run(0, -1);
        model_h(0, 8);
        check("post_rst_latency", 64'(lat), 64'd40);
        check_ram("post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
